// File: rtl/guess_entry.sv
// guess_entry -- digit-entry and scoring core for a four-digit "bulls and cows"
// guessing game.
//
// The raw enter button is synchronised and debounced. Each accepted press
// shifts one switch digit into the current guess. A digit is rejected if it
// is invalid or is already in the guess. When four digits are in, the guess
// is scored against the secret for one cycle. The game then goes on,
// or ends as won or lost.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   num          switch digit 0-9 (15 = invalid)
//   nonerror     1 = num holds a valid digit
//   key_n        raw active-low enter button, asynchronous to clk
//   new_game     synchronous restart request, sampled every cycle
//   secret       four BCD digits, [15:12] leftmost
//   guess        entered digits, 4'hF marks a blank position
//   digit_cnt    digits entered in the current guess (0-4)
//   a_cnt        last score: right digit in the right position
//   b_cnt        last score: right digit in the wrong position
//   result_valid one-cycle pulse when a_cnt/b_cnt update
//   err          one-cycle pulse on a rejected entry
//   attempts     scored guesses this game
//   win / lose   high while the game is won / lost
module guess_entry #(
  parameter int DEB_CYCLES = 4,
  parameter int MAX_TRIES  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  num,
  input  logic        nonerror,
  input  logic        key_n,
  input  logic        new_game,
  input  logic [15:0] secret,
  output logic [15:0] guess,
  output logic [2:0]  digit_cnt,
  output logic [2:0]  a_cnt,
  output logic [2:0]  b_cnt,
  output logic        result_valid,
  output logic        err,
  output logic [3:0]  attempts,
  output logic        win,
  output logic        lose
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [3:0]       TRIES_MAX = 4'(MAX_TRIES);

  typedef enum logic [1:0] {ENTRY, COMPARE, WON, LOST} state_t;

  state_t           state;
  logic             key_meta;
  logic             key_sync;
  logic             key_level;   // debounced button level, 1 = released
  logic [CNT_W-1:0] deb_cnt;
  logic             accept;
  logic [2:0]       score_a;
  logic [2:0]       score_b;
  logic [3:0]       attempts_inc;

  // Count the positions where the guess digit equals the secret digit.
  function automatic logic [2:0] count_a(input logic [15:0] g, input logic [15:0] s);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++)
      if (g[4*i +: 4] == s[4*i +: 4]) n = n + 3'd1;
    return n;
  endfunction

  // Count the pairs (i, j), i != j, where guess digit i equals secret digit j.
  function automatic logic [2:0] count_b(input logic [15:0] g, input logic [15:0] s);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (i != j && g[4*i +: 4] == s[4*j +: 4]) n = n + 3'd1;
    return n;
  endfunction

  // Blank positions hold 4'hF and so never match a digit in range.
  function automatic logic is_dup(input logic [15:0] g, input logic [3:0] d);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++)
      if (g[4*i +: 4] == d) hit = 1'b1;
    return hit;
  endfunction

  assign score_a      = count_a(guess, secret);
  assign score_b      = count_b(guess, secret);
  assign attempts_inc = attempts + 4'd1;

  // Button synchroniser and debouncer. The level flips only after the
  // synchronised input has differed from it for DEB_CYCLES cycles in a row.
  // A press produces a one-cycle accept pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_meta  <= 1'b1;
      key_sync  <= 1'b1;
      key_level <= 1'b1;
      deb_cnt   <= '0;
      accept    <= 1'b0;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
      accept   <= 1'b0;
      if (key_sync != key_level) begin
        if (deb_cnt == CNT_LAST) begin
          key_level <= key_sync;
          deb_cnt   <= '0;
          accept    <= ~key_sync;
        end else begin
          deb_cnt <= deb_cnt + CNT_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Game FSM. All outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ENTRY;
      guess        <= 16'hFFFF;
      digit_cnt    <= 3'd0;
      a_cnt        <= 3'd0;
      b_cnt        <= 3'd0;
      attempts     <= 4'd0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      win          <= 1'b0;
      lose         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      err          <= 1'b0;
      if (new_game) begin
        // Restart takes priority over any accept or scoring in this cycle.
        state     <= ENTRY;
        guess     <= 16'hFFFF;
        digit_cnt <= 3'd0;
        a_cnt     <= 3'd0;
        b_cnt     <= 3'd0;
        attempts  <= 4'd0;
        win       <= 1'b0;
        lose      <= 1'b0;
      end else begin
        case (state)
          ENTRY: begin
            if (accept) begin
              if (!nonerror || num > 4'd9 || is_dup(guess, num)) begin
                err <= 1'b1;
              end else begin
                guess     <= {guess[11:0], num};
                digit_cnt <= digit_cnt + 3'd1;
                if (digit_cnt == 3'd3) state <= COMPARE;
              end
            end
          end
          COMPARE: begin
            a_cnt        <= score_a;
            b_cnt        <= score_b;
            result_valid <= 1'b1;
            attempts     <= attempts_inc;
            if (score_a == 3'd4) begin
              state <= WON;
              win   <= 1'b1;
            end else if (attempts_inc == TRIES_MAX) begin
              state <= LOST;
              lose  <= 1'b1;
            end else begin
              state     <= ENTRY;
              guess     <= 16'hFFFF;
              digit_cnt <= 3'd0;
            end
          end
          WON, LOST: begin
            // Game over: presses are ignored until new_game.
          end
          default: state <= ENTRY;
        endcase
      end
    end
  end

endmodule

// File: doc/guess_entry.md
GUESS_ENTRY -- requirements
Module: guess_entry

Interface
REQ-001 Parameter DEB_CYCLES, default 4, SHALL set consecutive stable cycles for a key press or release to be accepted.
REQ-002 Parameter MAX_TRIES, default 8, SHALL set the number of scored guesses before the game is lost.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 num  input  4  decoded switch digit 0-9; 15 = invalid.
REQ-006 nonerror  input  1  1 = num holds a valid digit.
REQ-007 key_n  input  1  raw active-low enter push button, asynchronous to clk.
REQ-008 new_game  input  1  synchronous restart request, level-sampled each cycle.
REQ-009 secret  input  16  four BCD digits, [15:12] leftmost, stable during play.
REQ-010 guess  output  16  entered digits, 4'hF = blank position.
REQ-011 digit_cnt  output  3  digits entered in the current guess, 0-4.
REQ-012 a_cnt  output  3  last score: right digit, right position.
REQ-013 b_cnt  output  3  last score: right digit, wrong position.
REQ-014 result_valid  output  1  one-cycle pulse when a_cnt and b_cnt update.
REQ-015 err  output  1  one-cycle pulse on a rejected entry.
REQ-016 attempts  output  4  scored guesses this game.
REQ-017 win  output  1  high while in WON.
REQ-018 lose  output  1  high while in LOST.

Function
REQ-019 key_n SHALL pass through a 2-flop synchronizer before any use.
REQ-020 Press acceptance: synchronized key low for DEB_CYCLES consecutive cycles after a released state yields exactly one accept pulse; release requires DEB_CYCLES consecutive high cycles; bounces shorter than DEB_CYCLES restart the count.
REQ-021 FSM states: ENTRY, COMPARE, WON, LOST.
REQ-022 ENTRY: on an accept, num and nonerror sampled that cycle; reject (err pulse next cycle, guess and digit_cnt unchanged) if nonerror=0, num>9, or num equals any digit already in the current guess.
REQ-023 ENTRY valid accept: guess <= {guess[11:0], num}, digit_cnt += 1; when digit_cnt becomes 4, next state COMPARE.
REQ-024 COMPARE (exactly one cycle): A = count of i with g[i]==s[i]; B = count of pairs i!=j with g[i]==s[j]; register into a_cnt/b_cnt, pulse result_valid, attempts += 1.
REQ-025 COMPARE exit: A==4 -> WON; else attempts (post-increment) == MAX_TRIES -> LOST; else ENTRY with guess <= 16'hFFFF, digit_cnt <= 0.
REQ-026 Latency: 4th accept -> result_valid high 2 clk edges later.
REQ-027 WON/LOST: accepts ignored, no err; guess, a_cnt, b_cnt, attempts held.
REQ-028 new_game=1 in any state SHALL next cycle enter ENTRY with guess=16'hFFFF, digit_cnt=0, a_cnt=b_cnt=0, attempts=0; it overrides a simultaneous accept or COMPARE transition.
REQ-029 a_cnt/b_cnt SHALL hold between COMPARE cycles, including across ENTRY.
REQ-030 attempts SHALL never exceed MAX_TRIES.

Reset
REQ-031 rst=1 SHALL immediately force ENTRY, guess=16'hFFFF, digit_cnt=0, a_cnt=0, b_cnt=0, attempts=0, result_valid=0, err=0, win=0, lose=0, debounce and synchronizer to released.
REQ-032 rst asserted mid-guess or mid-debounce SHALL discard partial entry; first press after release requires full debounce.

Verification
REQ-033 secret=16'h1234, enter 1,2,3,4 -> result_valid, a_cnt=4, b_cnt=0, attempts=1, win=1.
REQ-034 secret=16'h1234, enter 4,3,2,1 -> a_cnt=0, b_cnt=4, state ENTRY, guess=16'hFFFF, digit_cnt=0.
REQ-035 enter 5, then 5 -> err pulse, digit_cnt=1, guess=16'hFFF5; then nonerror=0 press -> err, no change.
REQ-036 MAX_TRIES=2, secret=16'h1234, guesses 5678, 5679 -> second result_valid with lose=1, attempts=2; further presses no effect; new_game -> ENTRY, attempts=0.
REQ-037 key_n bounce of DEB_CYCLES-1 low cycles -> no accept; hold low 3*DEB_CYCLES -> exactly one digit entered.
REQ-038 rst pulse after 2 digits -> guess=16'hFFFF, digit_cnt=0 same cycle; new_game coincident with accept -> digit discarded.
